// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte-addressable data memory with sized,
// extended loads, lane-masked stores, PC source resolution, sticky halt and a debug port.
module mem_access_stage #(
    parameter int NB           = 32,
    parameter int NB_SIZE_TYPE = 3,
    parameter int MEM_DEPTH    = 32,
    parameter int NB_ADDR      = 5
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic [NB-1:0]           i_alu_result,
    input  logic [NB-1:0]           i_data_b_to_write,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_signed,
    input  logic [NB_SIZE_TYPE-1:0] i_word_size,
    input  logic                    i_cero,
    input  logic                    i_branch,
    input  logic                    i_jump,
    input  logic                    i_jr_jalr,
    input  logic                    i_halt,
    input  logic [NB_ADDR-1:0]      i_debug_addr,
    output logic [NB-1:0]           o_read_data,
    output logic [1:0]              o_pc_src,
    output logic                    o_misaligned,
    output logic                    o_halted,
    output logic [NB-1:0]           o_debug_data
);

    localparam int NB_LANES = NB / 8;

    logic [NB-1:0]       mem_q [MEM_DEPTH];
    logic                halted_q;

    logic [NB_ADDR-1:0]  word_idx;
    logic [1:0]          offset;
    logic                is_byte;
    logic                is_half;
    logic                is_word;
    logic                bad_access;
    logic                store_en;
    logic [NB_LANES-1:0] lane_en;
    logic [NB-1:0]       store_data;
    logic [NB-1:0]       cur_word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic                unused_addr_bits;

    assign word_idx = i_alu_result[NB_ADDR+1:2];
    assign offset   = i_alu_result[1:0];
    // Upper address bits are dropped so accesses wrap around the memory.
    assign unused_addr_bits = ^i_alu_result[NB-1:NB_ADDR+2];

    assign is_byte = (i_word_size == 3'b001);
    assign is_half = (i_word_size == 3'b010);
    assign is_word = (i_word_size == 3'b100);

    assign bad_access = ~(is_byte | is_half | is_word)
                      | (is_half & offset[0])
                      | (is_word & (offset != 2'b00));

    assign o_misaligned = (i_mem_read | i_mem_write) & bad_access;

    // A halt in the same step still lets its store through because halted_q is not yet set.
    assign store_en = i_step & i_mem_write & ~bad_access & ~halted_q;

    always_comb begin
        lane_en    = '0;
        store_data = i_data_b_to_write;
        if (is_byte) begin
            lane_en    = NB_LANES'(1) << offset;
            store_data = {NB_LANES{i_data_b_to_write[7:0]}};
        end else if (is_half) begin
            lane_en    = NB_LANES'(3) << offset;
            store_data = {(NB / 16){i_data_b_to_write[15:0]}};
        end else if (is_word) begin
            lane_en    = '1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            halted_q <= 1'b0;
        end else begin
            if (store_en) begin
                for (int l = 0; l < NB_LANES; l++) begin
                    if (lane_en[l]) begin
                        mem_q[word_idx][l*8 +: 8] <= store_data[l*8 +: 8];
                    end
                end
            end
            if (i_step && i_halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign cur_word = mem_q[word_idx];
    assign byte_sel = cur_word[{offset, 3'b000} +: 8];
    assign half_sel = cur_word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        o_read_data = '0;
        if (i_mem_read && !bad_access) begin
            if (is_byte) begin
                o_read_data = {{(NB - 8){i_signed & byte_sel[7]}}, byte_sel};
            end else if (is_half) begin
                o_read_data = {{(NB - 16){i_signed & half_sel[15]}}, half_sel};
            end else begin
                o_read_data = cur_word;
            end
        end
    end

    always_comb begin
        o_pc_src = 2'b00;
        if (i_jr_jalr) begin
            o_pc_src = 2'b11;
        end else if (i_jump) begin
            o_pc_src = 2'b10;
        end else if (i_branch && i_cero) begin
            o_pc_src = 2'b01;
        end
    end

    assign o_halted     = halted_q;
    assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM register and consumes its outputs.
- Holds the byte-addressable data memory and performs byte/half/word loads and stores, with sign or zero extension on loads.
- Resolves the PC source: branch taken, jump, or jr/jalr.
- Latches halt and exposes a debug read port, so the debug unit can dump memory after the program ends.

Parameters:
- NB, 32, datapath width in bits.
- NB_SIZE_TYPE, 3, width of the word-size code.
- MEM_DEPTH, 32, number of 32-bit words in data memory.
- NB_ADDR, 5, word-index width, equal to log2(MEM_DEPTH).

Ports:
- i_clk  in  1  clock; memory writes on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_step  in  1  pipeline advance enable; no state changes when 0.
- i_alu_result  in  NB  byte address for load/store; pass-through for writeback.
- i_data_b_to_write  in  NB  store data (rt).
- i_mem_read  in  1  load request.
- i_mem_write  in  1  store request.
- i_signed  in  1  1 = sign-extend load, 0 = zero-extend.
- i_word_size  in  NB_SIZE_TYPE  3'b001 byte, 3'b010 half, 3'b100 word; any other code = illegal.
- i_cero  in  1  ALU zero flag.
- i_branch  in  1  conditional branch.
- i_jump  in  1  j/jal.
- i_jr_jalr  in  1  jr/jalr.
- i_halt  in  1  halt instruction reached MEM.
- i_debug_addr  in  NB_ADDR  debug word index.
- o_read_data  out  NB  extended load data, combinational.
- o_pc_src  out  2  00 pc+4, 01 branch, 10 jump, 11 jr/jalr.
- o_misaligned  out  1  current access misaligned or illegal size.
- o_halted  out  1  sticky halt flag.
- o_debug_data  out  NB  memory word at i_debug_addr, combinational.

Behaviour:
- Reset (i_reset = 0, asynchronous):
  - all memory words cleared to 0;
  - o_halted = 0;
  - combinational outputs follow from the cleared state: o_read_data = 0, o_debug_data = 0.
- Addressing:
  - word index = i_alu_result[NB_ADDR+1:2];
  - byte offset = i_alu_result[1:0];
  - upper address bits are ignored, so addresses wrap modulo 4*MEM_DEPTH.
- Alignment:
  - half requires offset[0] = 0; word requires offset = 0; byte is always aligned.
  - o_misaligned = (i_mem_read | i_mem_write) & (misaligned | illegal size).
- Stores:
  - on rising edge with i_step = 1, i_mem_write = 1 and no misalignment, write the selected lanes only.
  - byte: rt[7:0] goes to lane = offset.
  - half: rt[15:0] goes to lanes offset and offset+1.
  - word: full word.
  - misaligned store: memory unchanged.
- Loads (combinational from current memory contents):
  - select the byte or half at the offset, then sign- or zero-extend per i_signed.
  - o_read_data = 0 when i_mem_read = 0 or the load is misaligned.
- Same-cycle read and write to the same word: a load sees the pre-write contents; the new value is visible on the next cycle.
- PC source, priority jr_jalr > jump > branch:
  - 11 if i_jr_jalr;
  - else 10 if i_jump;
  - else 01 if i_branch & i_cero;
  - else 00.
  - Purely combinational, independent of i_step.
- Halt:
  - on rising edge with i_step = 1 and i_halt = 1, o_halted becomes 1 and stays 1 until reset.
  - A store presented in the same step as halt is still performed.
  - Once o_halted = 1, further stores are blocked even if i_step = 1.
- Debug port:
  - o_debug_data = mem[i_debug_addr]; always readable, including while halted.
- Reset mid-store: reset wins and memory is cleared.

Test Plan:
- Reset, then read all 32 debug addresses -> every o_debug_data = 0; o_halted = 0.
- Word store 0xDEADBEEF at address 0x08, then word load from 0x08 -> o_read_data = 0xDEADBEEF; o_debug_data at index 2 = 0xDEADBEEF.
- Byte store 0x80 at address 0x0D over a zero word, then load:
  - signed byte -> 0xFFFFFF80;
  - unsigned byte -> 0x00000080;
  - word at 0x0C -> 0x00008000.
- Misaligned accesses:
  - half store at 0x03 -> o_misaligned = 1, memory unchanged;
  - word load at 0x06 -> o_misaligned = 1, o_read_data = 0.
- PC source:
  - i_branch = 1, i_cero = 1 -> 01;
  - i_branch = 1, i_cero = 0 -> 00;
  - i_jump = 1, i_jr_jalr = 1 -> 11.
- Halt:
  - i_halt with i_step -> o_halted = 1;
  - a later word store of 0x1234 at 0x00 -> memory unchanged;
  - drive i_reset low asynchronously -> o_halted = 0 immediately and memory cleared.
